vmem_arbiter: RTL and testbench

Single-port video memory arbiter sitting between the VGA scanout path, a buffered pixel-write requester (keyboard/console logic), and a built-in screen-clear engine. It owns the one physical memory port, grants VGA pixel fetches absolute priority so scanout never stalls, and drains writes and clear traffic in the remaining cycles. The memory address is {h[9:0], v[8:0]}, matching the existing framebuffer layout.

---
 rtl/vmem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_vmem_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_arbiter.sv
// rtl/vmem_arbiter.sv - single-port video memory arbiter; clear engine enabled by VMEM_ARBITER_CLEAR_EN
module vmem_arbiter #(
  parameter int H_MAX      = 640,
  parameter int V_MAX      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        vga_req,
  input  logic [9:0]  vga_h,
  input  logic [8:0]  vga_v,
  output logic [23:0] vga_rdata,
  output logic        vga_rvalid,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [9:0]  wr_h,
  input  logic [8:0]  wr_v,
  input  logic [23:0] wr_data,
  output logic        wr_drop,
  input  logic        clr_start,
  input  logic [23:0] clr_color,
  output logic        clr_busy,
  output logic        mem_en,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [23:0] mem_wdata,
  input  logic [23:0] mem_rdata
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = 43;
  localparam logic [9:0]    H_LIM   = 10'(H_MAX);
  localparam logic [8:0]    V_LIM   = 9'(V_MAX);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // FIFO entry layout: {h[9:0], v[8:0], data[23:0]}; the top 19 bits double as the memory address
  logic [EW-1:0] fifo_q [FIFO_DEPTH];
  logic [EW-1:0] fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rdy_en_q, rdy_en_d;
  logic          wr_drop_q, wr_drop_d;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [18:0]   mem_addr_q, mem_addr_d;
  logic [23:0]   mem_wdata_q, mem_wdata_d;
  logic          rd_pend_q, rd_pend_d;
  logic          vga_rvalid_q, vga_rvalid_d;
  logic [23:0]   vga_rdata_q, vga_rdata_d;
  logic          push, push_ok, in_range, pop;
  logic [EW-1:0] head;

`ifdef VMEM_ARBITER_CLEAR_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  state_t      state_q, state_d;
  logic [9:0]  clr_h_q, clr_h_d;
  logic [8:0]  clr_v_q, clr_v_d;
  logic [23:0] clr_color_q, clr_color_d;
  logic        clr_busy_q, clr_busy_d;
  assign clr_busy = clr_busy_q;
`else
  logic unused_clr;
  assign unused_clr = ^{clr_start, clr_color};
  assign clr_busy   = 1'b0;
`endif

  // rdy_en keeps wr_ready low until the first edge after reset release
  assign wr_ready   = rdy_en_q & (count_q < DEPTH_C);
  assign wr_drop    = wr_drop_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign vga_rvalid = vga_rvalid_q;
  assign vga_rdata  = vga_rdata_q;

  // Next-state: port grant (VGA > clear > FIFO head), read-return pipeline, FIFO bookkeeping
  always_comb begin
    fifo_d       = fifo_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    rdy_en_d     = 1'b1;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    // a read on the port this cycle returns data next cycle; capture it then
    rd_pend_d    = mem_en_q & ~mem_we_q;
    vga_rvalid_d = rd_pend_q;
    vga_rdata_d  = rd_pend_q ? mem_rdata : vga_rdata_q;
    push         = wr_valid & wr_ready;
    in_range     = (wr_h < H_LIM) && (wr_v < V_LIM);
    push_ok      = push & in_range;
    wr_drop_d    = push & ~in_range;
    head         = fifo_q[rptr_q];
    pop          = 1'b0;
`ifdef VMEM_ARBITER_CLEAR_EN
    state_d      = state_q;
    clr_h_d      = clr_h_q;
    clr_v_d      = clr_v_q;
    clr_color_d  = clr_color_q;
    clr_busy_d   = clr_busy_q;
`endif

    if (vga_req) begin
      mem_en_d   = 1'b1;
      mem_addr_d = {vga_h, vga_v};
    end
`ifdef VMEM_ARBITER_CLEAR_EN
    else if (state_q == S_CLEAR) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = {clr_h_q, clr_v_q};
      mem_wdata_d = clr_color_q;
      if (clr_h_q == H_LIM - 10'd1) begin
        clr_h_d = 10'd0;
        if (clr_v_q == V_LIM - 9'd1) begin
          clr_v_d    = 9'd0;
          state_d    = S_IDLE;
          clr_busy_d = 1'b0;
        end else begin
          clr_v_d = clr_v_q + 9'd1;
        end
      end else begin
        clr_h_d = clr_h_q + 10'd1;
      end
    end
`endif
    else if (count_q != '0) begin
      pop         = 1'b1;
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = head[42:24];
      mem_wdata_d = head[23:0];
      rptr_d      = rptr_q + PW'(1);
    end

`ifdef VMEM_ARBITER_CLEAR_EN
    if (state_q == S_IDLE && clr_start) begin
      state_d     = S_CLEAR;
      clr_color_d = clr_color;
      clr_h_d     = 10'd0;
      clr_v_d     = 9'd0;
      clr_busy_d  = 1'b1;
    end
`endif

    if (push_ok) begin
      fifo_d[wptr_q] = {wr_h, wr_v, wr_data};
      wptr_d         = wptr_q + PW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop);
  end

  // State registers; reset aborts any clear and flushes the FIFO at once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rdy_en_q     <= 1'b0;
      wr_drop_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_pend_q    <= 1'b0;
      vga_rvalid_q <= 1'b0;
      vga_rdata_q  <= '0;
`ifdef VMEM_ARBITER_CLEAR_EN
      state_q      <= S_IDLE;
      clr_h_q      <= '0;
      clr_v_q      <= '0;
      clr_color_q  <= '0;
      clr_busy_q   <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      rdy_en_q     <= rdy_en_d;
      wr_drop_q    <= wr_drop_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_pend_q    <= rd_pend_d;
      vga_rvalid_q <= vga_rvalid_d;
      vga_rdata_q  <= vga_rdata_d;
`ifdef VMEM_ARBITER_CLEAR_EN
      state_q      <= state_d;
      clr_h_q      <= clr_h_d;
      clr_v_q      <= clr_v_d;
      clr_color_q  <= clr_color_d;
      clr_busy_q   <= clr_busy_d;
`endif
    end
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// tb/tb_vmem_arbiter.sv - scoreboard bench for vmem_arbiter (small 4x2 screen)
module tb_vmem_arbiter;
  localparam int H = 4;
  localparam int V = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        vga_req = 1'b0;
  logic [9:0]  vga_h = '0;
  logic [8:0]  vga_v = '0;
  logic [23:0] vga_rdata;
  logic        vga_rvalid;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [9:0]  wr_h = '0;
  logic [8:0]  wr_v = '0;
  logic [23:0] wr_data = '0;
  logic        wr_drop;
  logic        clr_start = 1'b0;
  logic [23:0] clr_color = '0;
  logic        clr_busy;
  logic        mem_en, mem_we;
  logic [18:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata = '0;

  always #5 clk = ~clk;

  vmem_arbiter #(.H_MAX(H), .V_MAX(V), .FIFO_DEPTH(D)) dut (
    .clk(clk), .resetn(resetn),
    .vga_req(vga_req), .vga_h(vga_h), .vga_v(vga_v),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_h(wr_h), .wr_v(wr_v),
    .wr_data(wr_data), .wr_drop(wr_drop),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {logic we; logic [18:0] a; logic [23:0] d; int c;} acc_t;
  typedef struct {int c; logic [23:0] d;} rd_t;

  acc_t        exp_q[$];
  rd_t         rd_q[$];
  logic [23:0] mem [64];
  int          total = 0, bad = 0, cyc = 0, n_acc = 0;
  logic        p_en = 1'b0, p_we = 1'b0;
  logic [18:0] p_a = '0;
  logic [23:0] p_d = '0;

  // the bench memory only decodes h[2:0], v[2:0]; all coordinates used stay below 8
  function automatic int midx(input logic [18:0] a);
    return int'({a[11:9], a[2:0]});
  endfunction

  function automatic logic [18:0] ad(input int h, input int v);
    return {10'(h), 9'(v)};
  endfunction

  task automatic push_acc(input logic we, input logic [18:0] a, input logic [23:0] d, input int c);
    acc_t e;
    e.we = we; e.a = a; e.d = d; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [18:0] a);
    rd_t r;
    push_acc(1'b0, a, 24'h0, cyc + 1);
    r.c = cyc + 3; r.d = mem[midx(a)];
    rd_q.push_back(r);
  endtask

  // sample point: compare bus activity and read returns against the scoreboard
  task automatic half();
    acc_t e;
    rd_t  r;
    @(negedge clk);
    if (mem_en) begin
      n_acc++;
      p_en = 1'b1; p_we = mem_we; p_a = mem_addr; p_d = mem_wdata;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_access: got we=%0b addr=%h data=%h cyc=%0d, required no access", mem_we, mem_addr, mem_wdata, cyc);
      end else begin
        e = exp_q.pop_front();
        if (mem_we !== e.we || mem_addr !== e.a || (e.we && mem_wdata !== e.d) || (e.c >= 0 && cyc != e.c)) begin
          bad++;
          $display("FAIL mem_access: got we=%0b addr=%h data=%h cyc=%0d, required we=%0b addr=%h data=%h cyc=%0d",
                   mem_we, mem_addr, mem_wdata, cyc, e.we, e.a, e.d, e.c);
        end
      end
    end
    if (vga_rvalid) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rvalid: got data=%h cyc=%0d, required none", vga_rdata, cyc);
      end else begin
        r = rd_q.pop_front();
        if (vga_rdata !== r.d || cyc != r.c) begin
          bad++;
          $display("FAIL vga_rdata: got %h cyc=%0d, required %h cyc=%0d", vga_rdata, cyc, r.d, r.c);
        end
      end
    end
  endtask

  // drive point: just after the rising edge; the synchronous RAM model updates here
  task automatic edge_();
    @(posedge clk);
    #1;
    cyc++;
    if (p_en) begin
      if (p_we) mem[midx(p_a)] = p_d;
      else      mem_rdata = mem[midx(p_a)];
      p_en = 1'b0;
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin half(); edge_(); end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0 || rd_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drained: got pending acc=%0d rd=%0d, required 0 0", name, exp_q.size(), rd_q.size());
    end
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    edge_();
    half();
    total++;
    if ({vga_rdata, vga_rvalid, wr_ready, wr_drop, clr_busy, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_values: got rdata=%h rv=%b rdy=%b drop=%b busy=%b en=%b we=%b addr=%h wd=%h, required all 0",
               vga_rdata, vga_rvalid, wr_ready, wr_drop, clr_busy, mem_en, mem_we, mem_addr, mem_wdata);
    end
    edge_();
    resetn = 1'b1;
    half();
    total++;
    if (wr_ready !== 1'b0) begin bad++; $display("FAIL ready_at_release: got %b, required 0", wr_ready); end
    edge_();
    half();
    total++;
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release: got %b, required 1", wr_ready); end
    edge_();
    tick(5);
    check_drained("reset_idle");
  endtask

  task automatic test_vga_read();
    logic [18:0] a[3];
    a[0] = ad(3, 7); a[1] = ad(5, 1); a[2] = ad(0, 3);
    mem[midx(a[0])] = 24'h123456;
    mem[midx(a[1])] = 24'hABCDEF;
    mem[midx(a[2])] = 24'h000001;
    for (int i = 0; i < 3; i++) begin
      vga_req = 1'b1; vga_h = a[i][18:9]; vga_v = a[i][8:0];
      push_rd(a[i]);
      tick(1);
    end
    vga_req = 1'b0;
    tick(6);
    half();
    total++;
    if (vga_rdata !== 24'h000001 || vga_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rdata_hold: got %h rv=%b, required 000001 rv=0", vga_rdata, vga_rvalid);
    end
    edge_();
    check_drained("vga_read");
  endtask

  task automatic test_back_to_back();
    acc_t wq[$];
    acc_t e;
    int   r, acc_cyc;
    logic got;
    vga_req = 1'b1; vga_h = '0; vga_v = '0; wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_h = 10'(i % 4); wr_v = 9'(i / 4); wr_data = 24'hA00000 + 24'(i);
      push_rd(ad(0, 0));
      half();
      total++;
      if (wr_ready !== (i < 4)) begin bad++; $display("FAIL ready_fill_%0d: got %b, required %b", i, wr_ready, i < 4); end
      if (wr_ready) begin
        e.we = 1'b1; e.a = {wr_h, wr_v}; e.d = wr_data; e.c = 0;
        wq.push_back(e);
      end
      edge_();
    end
    vga_req = 1'b0;
    r = cyc;
    for (int i = 0; i < wq.size(); i++) push_acc(1'b1, wq[i].a, wq[i].d, r + 1 + i);
    got = 1'b0; acc_cyc = -1;
    for (int j = 0; j < 8 && !got; j++) begin
      half();
      if (wr_ready) begin got = 1'b1; acc_cyc = cyc; end
      edge_();
    end
    wr_valid = 1'b0;
    total++;
    if (!got || acc_cyc != r + 1) begin
      bad++;
      $display("FAIL fifth_accept: got accepted=%b cyc=%0d, required accepted=1 cyc=%0d", got, acc_cyc, r + 1);
    end
    push_acc(1'b1, ad(0, 1), 24'hA00004, r + 5);
    tick(8);
    check_drained("back_to_back");
  endtask

  task automatic test_drop();
    int          hs[4] = '{640, 0, 4, 3};
    int          vs[4] = '{0, 480, 0, 1};
    logic        dr[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_h = 10'(hs[i]); wr_v = 9'(vs[i]); wr_data = 24'h5A5A00 + 24'(i);
      if (!dr[i]) push_acc(1'b1, ad(hs[i], vs[i]), wr_data, cyc + 2);
      half();
      total++;
      if (wr_ready !== 1'b1) begin bad++; $display("FAIL drop_accept_%0d: got %b, required 1", i, wr_ready); end
      edge_();
      wr_valid = 1'b0;
      half();
      total++;
      if (wr_drop !== dr[i]) begin bad++; $display("FAIL wr_drop_%0d: got %b, required %b", i, wr_drop, dr[i]); end
      edge_();
      tick(3);
    end
    check_drained("drop");
  endtask

`ifdef VMEM_ARBITER_CLEAR_EN
  task automatic test_clear();
    int          s, busy_n;
    logic [23:0] want;
    s = cyc;
    clr_start = 1'b1; clr_color = 24'h00FF00;
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) push_acc(1'b1, ad(h, v), 24'h00FF00, s + 2 + v * H + h);
    push_acc(1'b1, ad(1, 1), 24'hFF0000, s + 2 + H * V);
    half();
    edge_();
    clr_start = 1'b0; clr_color = 24'h0000FF;
    busy_n = 0;
    for (int k = 0; k < 14; k++) begin
      if (k == 0) begin wr_valid = 1'b1; wr_h = 10'd1; wr_v = 9'd1; wr_data = 24'hFF0000; end
      if (k == 3) clr_start = 1'b1;
      half();
      if (clr_busy) busy_n++;
      if (k == 0) begin
        total++;
        if (clr_busy !== 1'b1 || wr_ready !== 1'b1) begin
          bad++;
          $display("FAIL clear_start: got busy=%b ready=%b, required busy=1 ready=1", clr_busy, wr_ready);
        end
      end
      edge_();
      wr_valid = 1'b0; clr_start = 1'b0;
    end
    total++;
    if (busy_n != H * V) begin bad++; $display("FAIL clear_busy_len: got %0d, required %0d", busy_n, H * V); end
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) begin
        want = (h == 1 && v == 1) ? 24'hFF0000 : 24'h00FF00;
        total++;
        if (mem[midx(ad(h, v))] !== want) begin
          bad++;
          $display("FAIL clear_pixel_%0d_%0d: got %h, required %h", h, v, mem[midx(ad(h, v))], want);
        end
      end
    check_drained("clear");
  endtask

  task automatic test_reset_mid_clear();
    int   base, n_after;
    logic hit;
    base = n_acc;
    clr_start = 1'b1; clr_color = 24'h123123;
    for (int h = 0; h < 3; h++) push_acc(1'b1, ad(h, 0), 24'h123123, cyc + 2 + h);
    half();
    edge_();
    clr_start = 1'b0;
    wr_valid = 1'b1; wr_h = 10'd2; wr_v = 9'd0; wr_data = 24'h777777;
    hit = 1'b0;
    for (int j = 0; j < 10 && !hit; j++) begin
      half();
      if (n_acc == base + 3) hit = 1'b1;
      else edge_();
      wr_valid = 1'b0;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL mid_clear_timeout: got %0d accesses, required 3", n_acc - base);
    end
    resetn = 1'b0;
    #1;
    total++;
    if (mem_en !== 1'b0 || clr_busy !== 1'b0 || wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_clear_reset: got en=%b busy=%b ready=%b, required 0 0 0", mem_en, clr_busy, wr_ready);
    end
    check_drained("mid_clear");
    edge_();
    edge_();
    resetn = 1'b1;
    n_after = n_acc;
    tick(12);
    total++;
    if (n_acc != n_after) begin bad++; $display("FAIL mid_clear_flush: got %0d accesses, required 0", n_acc - n_after); end
  endtask
`else
  task automatic test_clear();
    clr_start = 1'b1; clr_color = 24'h00FF00;
    wr_valid = 1'b1; wr_h = 10'd2; wr_v = 9'd1; wr_data = 24'h0000AA;
    push_acc(1'b1, ad(2, 1), 24'h0000AA, cyc + 2);
    half();
    edge_();
    clr_start = 1'b0; wr_valid = 1'b0;
    half();
    total++;
    if (clr_busy !== 1'b0) begin bad++; $display("FAIL clear_disabled_busy: got %b, required 0", clr_busy); end
    edge_();
    tick(4);
    total++;
    if (mem[midx(ad(2, 1))] !== 24'h0000AA) begin
      bad++;
      $display("FAIL clear_disabled_pixel: got %h, required 0000aa", mem[midx(ad(2, 1))]);
    end
    check_drained("clear_disabled");
  endtask
`endif

  task automatic test_reset_flush();
    int n_after;
    vga_req = 1'b1; vga_h = 10'd0; vga_v = 9'd0;
    wr_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_h = 10'(i); wr_v = 9'd1; wr_data = 24'hBEEF00 + 24'(i);
      push_rd(ad(0, 0));
      tick(1);
    end
    wr_valid = 1'b0;
    resetn = 1'b0;
    #1;
    total++;
    if (mem_en !== 1'b0 || vga_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL flush_reset: got en=%b rv=%b, required 0 0", mem_en, vga_rvalid);
    end
    exp_q.delete();
    rd_q.delete();
    vga_req = 1'b0;
    edge_();
    edge_();
    resetn = 1'b1;
    n_after = n_acc;
    tick(10);
    total++;
    if (n_acc != n_after) begin bad++; $display("FAIL flush_no_writes: got %0d accesses, required 0", n_acc - n_after); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_vga_read();
    test_back_to_back();
    test_drop();
    test_clear();
`ifdef VMEM_ARBITER_CLEAR_EN
    test_reset_mid_clear();
`endif
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end
endmodule
